multdiv_unit: RTL

//   Iterative signed 32-bit multiply/divide unit consumed by the execute (DX->XM) stage of the
//   5-stage pipeline for mul/div R-type ops (ALU opcode 00110 / 00111).
//   The execute stage pulses a start control with the bypassed operands and stalls F/D/X until

---
 rtl/multdiv_unit_if.sv | 23 ++
 rtl/multdiv_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/multdiv_unit_if.sv
// Operand/start/result bundle between the execute stage and the iterative multiply/divide unit.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic signed [WIDTH-1:0] data_operandA;
    logic signed [WIDTH-1:0] data_operandB;
    logic                    ctrl_MULT;
    logic                    ctrl_DIV;
    logic signed [WIDTH-1:0] data_result;
    logic                    data_exception;
    logic                    data_resultRDY;
    logic                    busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) / divide (restoring), one bit per cycle, fixed latency.
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic           clock,
    input  logic           reset,
    multdiv_unit_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]           acc_q, acc_d;
    logic [WIDTH-1:0]        opnd_q, opnd_d;
    logic                    is_div_q, is_div_d;
    logic                    neg_q, neg_d;
    logic signed [WIDTH-1:0] result_q, result_d;
    logic                    exc_q, exc_d;

    logic                    start;
    logic                    start_div;
    logic [WIDTH-1:0]        mag_a, mag_b;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          rem_shift;
    logic [WIDTH:0]          div_diff;
    logic [DW-1:0]           prod_signed;
    logic [WIDTH-1:0]        quot_mag;
    logic [WIDTH-1:0]        quot_signed;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [DW-1:0] cond_negate(input logic [DW-1:0] v, input logic neg);
        return neg ? (~v + DW'(1)) : v;
    endfunction

    // Signed overflow: the upper half plus the result sign bit must be a pure sign extension.
    function automatic logic mul_overflow(input logic [DW-1:0] p);
        logic [WIDTH:0] top;
        top = p[DW-1:WIDTH-1];
        return !((&top) || !(|top));
    endfunction

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign start_div = ~bus.ctrl_MULT;
    assign mag_a     = magnitude(bus.data_operandA);
    assign mag_b     = magnitude(bus.data_operandB);

    // acc holds {partial product high, multiplier} for mul and {remainder, quotient} for div.
    assign mul_sum     = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_shift   = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff    = rem_shift - {1'b0, opnd_q};
    assign prod_signed = cond_negate(acc_q, neg_q);
    assign quot_mag    = acc_q[WIDTH-1:0];
    assign quot_signed = neg_q ? (~quot_mag + WIDTH'(1)) : quot_mag;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    // A start in any state (re)launches an operation, aborting whatever was in flight.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        result_d = result_q;
        exc_d    = exc_q;
        if (start) begin
            cnt_d    = '0;
            is_div_d = start_div;
            neg_d    = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            opnd_d   = start_div ? mag_b : mag_a;
            acc_d    = {{WIDTH{1'b0}}, (start_div ? mag_a : mag_b)};
        end else if (state_q == RUN) begin
            if (cnt_q != LAST_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
                if (is_div_q) begin
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end
            end else if (is_div_q) begin
                // Zero divisor still runs the full count so latency stays fixed.
                if (opnd_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                end else begin
                    result_d = quot_signed;
                    exc_d    = ~neg_q & quot_mag[WIDTH-1];
                end
            end else begin
                result_d = prod_signed[WIDTH-1:0];
                exc_d    = mul_overflow(prod_signed);
            end
        end
    end

    always_comb begin
        bus.data_resultRDY = (state_q == DONE);
        bus.busy           = (state_q != IDLE);
        bus.data_result    = result_q;
        bus.data_exception = exc_q;
    end
endmodule
